// File: rtl/cnt_ctrl_pkg.sv
// rtl/cnt_ctrl_pkg.sv - shared opcodes, FSM states and default limit for the counter command controller
package cnt_ctrl_pkg;

    // Limit the downstream counter runs to after reset until software changes it.
    localparam logic [2:0] DEFAULT_LIMIT = 3'd7;

    typedef enum logic [1:0] {
        OP_SET_LIMIT  = 2'b00,
        OP_SET_MODE   = 2'b01,
        OP_CLEAR      = 2'b10,
        OP_LOAD_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_SETTLE
    } ctrl_state_e;

    // True for opcodes whose operand is a new counter limit.
    function automatic logic op_carries_limit(input cmd_op_e op);
        return (op == OP_SET_LIMIT) || (op == OP_LOAD_CLEAR);
    endfunction

endpackage

// File: rtl/cnt_cmd_ctrl_if.sv
// rtl/cnt_cmd_ctrl_if.sv - command valid/ready handshake between a command source and the controller
interface cnt_cmd_ctrl_if;
    import cnt_ctrl_pkg::*;

    logic        cmd_valid;
    cmd_op_e     cmd_op;
    logic [2:0]  cmd_data;
    logic        cmd_ready;

    // Command source side.
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    // Controller side.
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/cnt_cmd_ctrl.sv
// rtl/cnt_cmd_ctrl.sv - command controller driving limit, mode, load and clear strobes of an up/down counter
module cnt_cmd_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter logic [2:0] RST_LIMIT = DEFAULT_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cnt_cmd_ctrl_if.slave        cmd,
    output logic [2:0]           upper_limit,
    output logic                 load_en,
    output logic                 mode,
    output logic                 rst_count,
    output logic                 err
);

    ctrl_state_e state;
    // INIT spans the reset period plus one strobe cycle; this marks that the strobe has been issued.
    logic        init_done;
    // Set when a LOAD_CLEAR is in its LOAD cycle so the CLEAR cycle follows.
    logic        clear_pending;

    // Single registered FSM: every output is written for the state being entered, so outputs are pure flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            init_done     <= 1'b0;
            clear_pending <= 1'b0;
            upper_limit   <= RST_LIMIT;
            mode          <= 1'b0;
            err           <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            load_en       <= 1'b0;
            rst_count     <= 1'b0;
        end else begin
            load_en   <= 1'b0;
            rst_count <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (!init_done) begin
                        init_done   <= 1'b1;
                        load_en     <= 1'b1;
                        rst_count   <= 1'b1;
                        upper_limit <= RST_LIMIT;
                    end else begin
                        state         <= ST_IDLE;
                        cmd.cmd_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        if (op_carries_limit(cmd.cmd_op)) begin
                            // A zero limit would stall the counter: reject it and stay ready.
                            if (cmd.cmd_data == 3'd0) begin
                                err <= 1'b1;
                            end else begin
                                upper_limit   <= cmd.cmd_data;
                                load_en       <= 1'b1;
                                clear_pending <= (cmd.cmd_op == OP_LOAD_CLEAR);
                                state         <= ST_LOAD;
                                cmd.cmd_ready <= 1'b0;
                            end
                        end else if (cmd.cmd_op == OP_SET_MODE) begin
                            mode          <= cmd.cmd_data[0];
                            state         <= ST_SETTLE;
                            cmd.cmd_ready <= 1'b0;
                        end else begin
                            rst_count     <= 1'b1;
                            err           <= 1'b0;
                            state         <= ST_CLEAR;
                            cmd.cmd_ready <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (clear_pending) begin
                        clear_pending <= 1'b0;
                        rst_count     <= 1'b1;
                        err           <= 1'b0;
                        state         <= ST_CLEAR;
                    end else begin
                        state         <= ST_IDLE;
                        cmd.cmd_ready <= 1'b1;
                    end
                end
                ST_CLEAR, ST_SETTLE: begin
                    state         <= ST_IDLE;
                    cmd.cmd_ready <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    cmd.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_cmd_ctrl.sv
// tb/tb_cnt_cmd_ctrl.sv - self-checking bench for cnt_cmd_ctrl with an attached behavioural counter
module tb_cnt_cmd_ctrl;
    import cnt_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] upper_limit;
    logic       load_en, mode, rst_count, err;

    cnt_cmd_ctrl_if ifc ();

    cnt_cmd_ctrl #(.RST_LIMIT(3'd7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (ifc.slave),
        .upper_limit (upper_limit),
        .load_en     (load_en),
        .mode        (mode),
        .rst_count   (rst_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit run   = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour: each accepted command schedules the cycles it occupies.
    typedef enum {P_RST, P_INIT, P_IDLE, P_LOAD, P_CLR, P_SETTLE} phase_e;
    typedef struct {
        phase_e     ph;
        logic [2:0] val;
    } step_t;

    step_t      plan[$];
    step_t      nxt;
    phase_e     cur   = P_RST;
    logic [2:0] m_lim = 3'd7;
    logic       m_mode = 1'b0;
    logic       m_err  = 1'b0;

    // Model: advance one scheduled cycle per edge, schedule new work when idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur = P_RST;
            plan.delete();
            m_lim  = 3'd7;
            m_mode = 1'b0;
            m_err  = 1'b0;
        end else if (cur == P_RST) begin
            cur = P_INIT;
        end else begin
            if (cur == P_IDLE && ifc.cmd_valid === 1'b1) begin
                case (ifc.cmd_op)
                    OP_SET_LIMIT:
                        if (ifc.cmd_data == 3'd0) m_err = 1'b1;
                        else plan.push_back('{ph: P_LOAD, val: ifc.cmd_data});
                    OP_LOAD_CLEAR:
                        if (ifc.cmd_data == 3'd0) m_err = 1'b1;
                        else begin
                            plan.push_back('{ph: P_LOAD, val: ifc.cmd_data});
                            plan.push_back('{ph: P_CLR, val: 3'd0});
                        end
                    OP_SET_MODE: plan.push_back('{ph: P_SETTLE, val: ifc.cmd_data});
                    default:     plan.push_back('{ph: P_CLR, val: 3'd0});
                endcase
            end
            if (plan.size() > 0) begin
                nxt = plan.pop_front();
                cur = nxt.ph;
                if (nxt.ph == P_LOAD)   m_lim  = nxt.val;
                if (nxt.ph == P_CLR)    m_err  = 1'b0;
                if (nxt.ph == P_SETTLE) m_mode = nxt.val[0];
            end else begin
                cur = P_IDLE;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (run) begin
            chk("cmd_ready",   {7'd0, ifc.cmd_ready}, {7'd0, cur == P_IDLE});
            chk("load_en",     {7'd0, load_en},   {7'd0, (cur == P_LOAD) || (cur == P_INIT)});
            chk("rst_count",   {7'd0, rst_count}, {7'd0, (cur == P_CLR) || (cur == P_INIT)});
            chk("upper_limit", {5'd0, upper_limit}, {5'd0, m_lim});
            chk("mode",        {7'd0, mode}, {7'd0, m_mode});
            chk("err",         {7'd0, err},  {7'd0, m_err});
        end
    end

    // Downstream counter attached to the controller outputs.
    logic [2:0] cnt, cnt_lim;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 3'd0;
            cnt_lim <= 3'd7;
        end else begin
            if (load_en) cnt_lim <= upper_limit;
            if (rst_count) cnt <= 3'd0;
            else if (!load_en) begin
                if (!mode) cnt <= (cnt >= cnt_lim) ? 3'd0 : cnt + 3'd1;
                else       cnt <= (cnt == 3'd0) ? cnt_lim : cnt - 3'd1;
            end
        end
    end

    // Present a command at a falling edge and hold it until accepted; returns at the falling edge after acceptance.
    task automatic send(input cmd_op_e op, input logic [2:0] d);
        bit done = 1'b0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            if (ifc.cmd_ready === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("send_accepted", {7'd0, done}, 8'd1);
    endtask

    task automatic idle();
        ifc.cmd_valid = 1'b0;
    endtask

    int seq_down [8] = '{0, 5, 4, 3, 2, 1, 0, 5};

    initial begin
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = OP_SET_LIMIT;
        ifc.cmd_data  = 3'd0;
        #1 rst_n = 1'b0;
        #1 run = 1'b1;

        // Reset values.
        @(negedge clk);
        chk("rst_ready",  {7'd0, ifc.cmd_ready}, 8'd0);
        chk("rst_load",   {7'd0, load_en}, 8'd0);
        chk("rst_rc",     {7'd0, rst_count}, 8'd0);
        chk("rst_limit",  {5'd0, upper_limit}, 8'd7);
        chk("rst_mode",   {7'd0, mode}, 8'd0);
        chk("rst_err",    {7'd0, err}, 8'd0);
        rst_n = 1'b1;

        // INIT cycle, then IDLE; counter counts 0..7 and wraps.
        @(negedge clk);
        chk("init_load",  {7'd0, load_en}, 8'd1);
        chk("init_rc",    {7'd0, rst_count}, 8'd1);
        chk("init_limit", {5'd0, upper_limit}, 8'd7);
        chk("init_ready", {7'd0, ifc.cmd_ready}, 8'd0);
        @(negedge clk);
        chk("idle_ready", {7'd0, ifc.cmd_ready}, 8'd1);
        chk("cnt_start",  {5'd0, cnt}, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("cnt_up7", {5'd0, cnt}, 8'(i % 8));
        end

        // SET_LIMIT 3: one load strobe, counter wraps at 3.
        send(OP_SET_LIMIT, 3'd3);
        idle();
        chk("setlim_load",  {7'd0, load_en}, 8'd1);
        chk("setlim_value", {5'd0, upper_limit}, 8'd3);
        for (int i = 0; i < 20 && cnt != 3'd0; i++) @(negedge clk);
        chk("cnt_wrap_seen", {5'd0, cnt}, 8'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("cnt_up3", {5'd0, cnt}, 8'(i % 4));
        end

        // Zero limit rejected, then CLEAR clears err.
        send(OP_SET_LIMIT, 3'd0);
        idle();
        chk("zero_err",   {7'd0, err}, 8'd1);
        chk("zero_ready", {7'd0, ifc.cmd_ready}, 8'd1);
        chk("zero_load",  {7'd0, load_en}, 8'd0);
        chk("zero_limit", {5'd0, upper_limit}, 8'd3);
        send(OP_CLEAR, 3'd0);
        idle();
        chk("clear_rc",  {7'd0, rst_count}, 8'd1);
        chk("clear_err", {7'd0, err}, 8'd0);

        // SET_MODE 1 then LOAD_CLEAR 5: counter runs down from the new limit.
        send(OP_SET_MODE, 3'd1);
        idle();
        chk("mode_set",    {7'd0, mode}, 8'd1);
        chk("mode_settle", {7'd0, ifc.cmd_ready}, 8'd0);
        send(OP_LOAD_CLEAR, 3'd5);
        idle();
        chk("lc_load",  {7'd0, load_en}, 8'd1);
        chk("lc_limit", {5'd0, upper_limit}, 8'd5);
        @(negedge clk);
        chk("lc_rc",    {7'd0, rst_count}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("cnt_down5", {5'd0, cnt}, 8'(seq_down[i]));
        end

        // Four mixed commands with cmd_valid held high throughout.
        send(OP_SET_LIMIT, 3'd2);
        send(OP_SET_MODE, 3'd0);
        send(OP_SET_LIMIT, 3'd0);
        send(OP_LOAD_CLEAR, 3'd6);
        idle();
        repeat (3) @(negedge clk);
        chk("b2b_limit", {5'd0, upper_limit}, 8'd6);
        chk("b2b_mode",  {7'd0, mode}, 8'd0);
        chk("b2b_err",   {7'd0, err}, 8'd0);

        // Reset during the LOAD cycle of a LOAD_CLEAR.
        send(OP_SET_MODE, 3'd1);
        idle();
        send(OP_LOAD_CLEAR, 3'd4);
        idle();
        chk("mid_load", {7'd0, load_en}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", {7'd0, ifc.cmd_ready}, 8'd0);
        chk("async_load",  {7'd0, load_en}, 8'd0);
        chk("async_rc",    {7'd0, rst_count}, 8'd0);
        chk("async_limit", {5'd0, upper_limit}, 8'd7);
        chk("async_mode",  {7'd0, mode}, 8'd0);
        chk("async_err",   {7'd0, err}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reinit_load",  {7'd0, load_en}, 8'd1);
        chk("reinit_rc",    {7'd0, rst_count}, 8'd1);
        chk("reinit_ready", {7'd0, ifc.cmd_ready}, 8'd0);
        @(negedge clk);
        chk("reinit_idle",  {7'd0, ifc.cmd_ready}, 8'd1);
        repeat (3) @(negedge clk);

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
